// File: rtl/copro_alu_arbiter_pkg.sv
// Shared opcode encoding for the coprocessor ALU arbiter slice.
// NOP is the idle encoding driven to the ALU when no request is granted.
package copro_alu_arbiter_pkg;

  typedef enum logic [3:0] {
    NOP      = 4'h0,
    ROR64H   = 4'h1,
    ROR64L   = 4'h2,
    OP_ASCON = 4'h3
  } opcode_t;

endpackage

// File: rtl/copro_alu_arbiter_if.sv
// Issue-side, ALU-side and result-side signals of the coprocessor ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface copro_alu_arbiter_if
  import copro_alu_arbiter_pkg::*;
#(
  parameter int unsigned NrReq       = 2,
  parameter int unsigned NrRgprPorts = 3,
  parameter int unsigned XLEN        = 32,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic,
  parameter type         registers_t = logic [NrRgprPorts-1:0][XLEN-1:0]
);
  localparam int unsigned IdxW = $clog2(NrReq);

  logic [NrReq-1:0] req_valid_i;
  logic [NrReq-1:0] req_ready_o;
  opcode_t          req_opcode_i    [NrReq];
  registers_t       req_registers_i [NrReq];
  hartid_t          req_hartid_i    [NrReq];
  id_t              req_id_i        [NrReq];
  logic [4:0]       req_rd_i        [NrReq];
  logic [5:0]       req_imm_i       [NrReq];
  logic [1:0]       req_f2_i        [NrReq];

  opcode_t          alu_opcode_o;
  registers_t       alu_registers_o;
  hartid_t          alu_hartid_o;
  id_t              alu_id_o;
  logic [4:0]       alu_rd_o;
  logic [5:0]       alu_imm_o;
  logic [1:0]       alu_f2_o;

  logic [XLEN-1:0]  alu_result_i;
  logic             alu_valid_i;
  logic             alu_we_i;
  hartid_t          alu_hartid_i;
  id_t              alu_id_i;
  logic [4:0]       alu_rd_i;

  logic             res_valid_o;
  logic             res_ready_i;
  logic [IdxW-1:0]  res_req_idx_o;
  logic [XLEN-1:0]  res_result_o;
  hartid_t          res_hartid_o;
  id_t              res_id_o;
  logic [4:0]       res_rd_o;
  logic             res_we_o;
  logic             res_err_o;

  modport slave (
    input  req_valid_i, req_opcode_i, req_registers_i, req_hartid_i, req_id_i, req_rd_i,
           req_imm_i, req_f2_i,
    output req_ready_o,
    output alu_opcode_o, alu_registers_o, alu_hartid_o, alu_id_o, alu_rd_o, alu_imm_o, alu_f2_o,
    input  alu_result_i, alu_valid_i, alu_we_i, alu_hartid_i, alu_id_i, alu_rd_i,
    output res_valid_o, res_req_idx_o, res_result_o, res_hartid_o, res_id_o, res_rd_o,
           res_we_o, res_err_o,
    input  res_ready_i
  );

  modport master (
    output req_valid_i, req_opcode_i, req_registers_i, req_hartid_i, req_id_i, req_rd_i,
           req_imm_i, req_f2_i,
    input  req_ready_o,
    input  alu_opcode_o, alu_registers_o, alu_hartid_o, alu_id_o, alu_rd_o, alu_imm_o, alu_f2_o,
    output alu_result_i, alu_valid_i, alu_we_i, alu_hartid_i, alu_id_i, alu_rd_i,
    input  res_valid_o, res_req_idx_o, res_result_o, res_hartid_o, res_id_o, res_rd_o,
           res_we_o, res_err_o,
    output res_ready_i
  );

endinterface

// File: rtl/copro_res_fifo.sv
// Small synchronous-reset FIFO for ALU result entries.
// count_o feeds the issue credit; head data reads as zero while empty.
module copro_res_fifo #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  entry_t          entry_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic            valid_o,
  output logic [CntW-1:0] count_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            pop;

  assign valid_o = (count_q != '0);
  assign pop     = pop_i & valid_o;
  assign count_o = count_q;
  assign head_o  = valid_o ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)    rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      count_q <= count_q + CntW'(push_i) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= entry_i;
  end

  // Issue credit must make a push into a full FIFO without a pop impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop && (count_q == CntW'(Depth))));

endmodule

// File: rtl/copro_alu_arbiter.sv
// Round-robin issue arbiter sharing one single-cycle ALU between NrReq requesters,
// with credit-limited issue into a result FIFO tagged by requester index.
module copro_alu_arbiter
  import copro_alu_arbiter_pkg::*;
#(
  parameter int unsigned NrReq       = 2,
  parameter int unsigned NrRgprPorts = 3,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ResDepth    = 2,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic,
  parameter type         registers_t = logic [NrRgprPorts-1:0][XLEN-1:0]
) (
  input logic                clk_i,
  input logic                rst_ni,
  copro_alu_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NrReq);
  localparam int unsigned CntW = $clog2(ResDepth + 1);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic [XLEN-1:0] result;
    hartid_t         hartid;
    id_t             id;
    logic [4:0]      rd;
    logic            we;
    logic            err;
  } entry_t;

  logic [IdxW-1:0] ptr_q, ptr_d, tag_q, gnt_idx;
  logic            gnt_valid, can_issue, inflight_q, pop, head_valid;
  hartid_t         hartid_q;
  id_t             id_q;
  logic [4:0]      rd_q;
  logic [CntW-1:0] count;
  entry_t          push_entry, head;

  assign pop       = head_valid & bus.res_ready_i;
  // Slots already promised (queued minus leaving plus in flight) must stay below depth.
  assign can_issue = (32'(count) - 32'(pop) + 32'(inflight_q)) < ResDepth;

  always_comb begin
    logic [IdxW:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NrReq; k++) begin
      cand = {1'b0, ptr_q} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(NrReq)) cand = cand - (IdxW + 1)'(NrReq);
      if (!gnt_valid && bus.req_valid_i[cand[IdxW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
    gnt_valid = gnt_valid & can_issue & rst_ni;
  end

  assign ptr_d = !gnt_valid ? ptr_q :
                 (gnt_idx == IdxW'(NrReq - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    bus.req_ready_o     = '0;
    bus.alu_opcode_o    = NOP;
    bus.alu_registers_o = '0;
    bus.alu_hartid_o    = '0;
    bus.alu_id_o        = '0;
    bus.alu_rd_o        = '0;
    bus.alu_imm_o       = '0;
    bus.alu_f2_o        = '0;
    if (gnt_valid) begin
      bus.req_ready_o[gnt_idx] = 1'b1;
      bus.alu_opcode_o         = bus.req_opcode_i[gnt_idx];
      bus.alu_registers_o      = bus.req_registers_i[gnt_idx];
      bus.alu_hartid_o         = bus.req_hartid_i[gnt_idx];
      bus.alu_id_o             = bus.req_id_i[gnt_idx];
      bus.alu_rd_o             = bus.req_rd_i[gnt_idx];
      bus.alu_imm_o            = bus.req_imm_i[gnt_idx];
      bus.alu_f2_o             = bus.req_f2_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      hartid_q   <= '0;
      id_q       <= '0;
      rd_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= gnt_valid;
      if (gnt_valid) begin
        tag_q    <= gnt_idx;
        hartid_q <= bus.alu_hartid_o;
        id_q     <= bus.alu_id_o;
        rd_q     <= bus.alu_rd_o;
      end
    end
  end

  // A rejected opcode still returns an entry so the requester sees the error.
  always_comb begin
    push_entry.idx = tag_q;
    if (bus.alu_valid_i) begin
      push_entry.result = bus.alu_result_i;
      push_entry.hartid = bus.alu_hartid_i;
      push_entry.id     = bus.alu_id_i;
      push_entry.rd     = bus.alu_rd_i;
      push_entry.we     = bus.alu_we_i;
      push_entry.err    = 1'b0;
    end else begin
      push_entry.result = '0;
      push_entry.hartid = hartid_q;
      push_entry.id     = id_q;
      push_entry.rd     = rd_q;
      push_entry.we     = 1'b0;
      push_entry.err    = 1'b1;
    end
  end

  copro_res_fifo #(
    .Depth   (ResDepth),
    .entry_t (entry_t)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (head_valid),
    .count_o (count)
  );

  assign bus.res_valid_o   = head_valid;
  assign bus.res_req_idx_o = head.idx;
  assign bus.res_result_o  = head.result;
  assign bus.res_hartid_o  = head.hartid;
  assign bus.res_id_o      = head.id;
  assign bus.res_rd_o      = head.rd;
  assign bus.res_we_o      = head.we;
  assign bus.res_err_o     = head.err;

endmodule

// File: tb/tb_copro_alu_arbiter.sv
// Directed bench for copro_alu_arbiter with a 1-cycle ALU model and a result scoreboard.
module tb_copro_alu_arbiter;
  import copro_alu_arbiter_pkg::*;

  localparam int unsigned NrReq    = 3;
  localparam int unsigned ResDepth = 2;

  typedef logic [3:0]       hartid_t;
  typedef logic [7:0]       id_t;
  typedef logic [2:0][31:0] regs_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] result;
    hartid_t     hartid;
    id_t         id;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [1:0] g;

  always #5 clk = ~clk;

  copro_alu_arbiter_if #(
    .NrReq(NrReq), .NrRgprPorts(3), .XLEN(32),
    .hartid_t(hartid_t), .id_t(id_t), .registers_t(regs_t)
  ) bus ();

  copro_alu_arbiter #(
    .NrReq(NrReq), .NrRgprPorts(3), .XLEN(32), .ResDepth(ResDepth),
    .hartid_t(hartid_t), .id_t(id_t), .registers_t(regs_t)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic logic [31:0] ror64h(input logic [31:0] hi, input logic [31:0] lo,
                                         input logic [5:0] sh);
    logic [63:0] v;
    v = {hi, lo};
    v = (v >> sh) | (v << (7'd64 - {1'b0, sh}));
    return v[63:32];
  endfunction

  function automatic logic [31:0] ascon(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return a ^ (~b & c);
  endfunction

  // ALU model: decodes only ROR64H and OP_ASCON, returns junk for anything else.
  always @(posedge clk) begin
    case (bus.alu_opcode_o)
      ROR64H: begin
        bus.alu_valid_i  <= 1'b1;
        bus.alu_result_i <= ror64h(bus.alu_registers_o[0], bus.alu_registers_o[1],
                                   bus.alu_imm_o);
        bus.alu_we_i     <= 1'b1;
        bus.alu_hartid_i <= bus.alu_hartid_o;
        bus.alu_id_i     <= bus.alu_id_o;
        bus.alu_rd_i     <= bus.alu_rd_o;
      end
      OP_ASCON: begin
        bus.alu_valid_i  <= 1'b1;
        bus.alu_result_i <= ascon(bus.alu_registers_o[0], bus.alu_registers_o[1],
                                  bus.alu_registers_o[2]);
        bus.alu_we_i     <= 1'b1;
        bus.alu_hartid_i <= bus.alu_hartid_o;
        bus.alu_id_i     <= bus.alu_id_o;
        bus.alu_rd_i     <= bus.alu_rd_o;
      end
      default: begin
        bus.alu_valid_i  <= 1'b0;
        bus.alu_result_i <= 32'hDEADBEEF;
        bus.alu_we_i     <= 1'b1;
        bus.alu_hartid_i <= ~bus.alu_hartid_o;
        bus.alu_id_i     <= ~bus.alu_id_o;
        bus.alu_rd_i     <= ~bus.alu_rd_o;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input opcode_t op, input logic [31:0] r0,
                         input logic [31:0] r1, input logic [31:0] r2, input hartid_t h,
                         input id_t d, input logic [4:0] rd, input logic [5:0] imm);
    bus.req_opcode_i[i]    = op;
    bus.req_registers_i[i] = {r2, r1, r0};
    bus.req_hartid_i[i]    = h;
    bus.req_id_i[i]        = d;
    bus.req_rd_i[i]        = rd;
    bus.req_imm_i[i]       = imm;
    bus.req_f2_i[i]        = 2'b00;
    bus.req_valid_i[i]     = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] idx, input logic [31:0] res, input hartid_t h,
                          input id_t d, input logic [4:0] rd, input logic we,
                          input logic err);
    exp_t e;
    e.idx = idx; e.result = res; e.hartid = h; e.id = d; e.rd = rd; e.we = we; e.err = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_result: observed=%0h expected=none", bus.res_result_o);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("res_idx", bus.res_req_idx_o, mon_e.idx);
        chk("res_result", bus.res_result_o, mon_e.result);
        chk("res_hartid", bus.res_hartid_o, mon_e.hartid);
        chk("res_id", bus.res_id_o, mon_e.id);
        chk("res_rd", bus.res_rd_o, mon_e.rd);
        chk("res_we", bus.res_we_o, mon_e.we);
        chk("res_err", bus.res_err_o, mon_e.err);
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.res_ready_i = 1'b1;
    bus.req_valid_i = '0;
    for (int i = 0; i < int'(NrReq); i++) set_req(2'(i), NOP, 0, 0, 0, 0, 0, 0, 0);
    bus.req_valid_i = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_res_valid", bus.res_valid_o, 1'b0);
    chk("rst_res_err", bus.res_err_o, 1'b0);
    chk("rst_res_we", bus.res_we_o, 1'b0);
    chk("rst_res_result", bus.res_result_o, 32'h0);
    chk("rst_ready", bus.req_ready_o, 3'b000);
    chk("rst_alu_op", bus.alu_opcode_o, NOP);

    // Single ROR64H from req0
    step();
    set_req(0, ROR64H, 32'h12345678, 32'h9ABCDEF0, 32'h0, 4'h1, 8'h11, 5'd5, 6'd8);
    #1;
    chk("t1_ready", bus.req_ready_o, 3'b001);
    chk("t1_alu_op", bus.alu_opcode_o, ROR64H);
    chk("t1_alu_imm", bus.alu_imm_o, 6'd8);
    push_exp(0, 32'hF0123456, 4'h1, 8'h11, 5'd5, 1'b1, 1'b0);
    step();
    bus.req_valid_i = '0;
    #1;
    chk("t1_lat_t1", bus.res_valid_o, 1'b0);
    chk("t1_idle_alu_op", bus.alu_opcode_o, NOP);
    step();
    chk("t1_lat_t2", bus.res_valid_o, 1'b1);
    chk("t1_result", bus.res_result_o, 32'hF0123456);
    chk("t1_rd", bus.res_rd_o, 5'd5);
    chk("t1_we", bus.res_we_o, 1'b1);
    chk("t1_idx", bus.res_req_idx_o, 2'd0);

    // req0 and req1 held valid: grants alternate starting at req1 (pointer now 1)
    step();
    set_req(0, ROR64H, 32'h0BADF00D, 32'hCAFEBABE, 32'h0, 4'h2, 8'h20, 5'd1, 6'd4);
    set_req(1, ROR64H, 32'h01234567, 32'h89ABCDEF, 32'h0, 4'h3, 8'h30, 5'd2, 6'd12);
    g = 2'd1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("alt_grant", bus.req_ready_o, 3'b001 << g);
      if (c >= 2) chk("alt_thru", bus.res_valid_o, 1'b1);
      push_exp(g, ror64h(bus.req_registers_i[g][0], bus.req_registers_i[g][1],
                         bus.req_imm_i[g]),
               bus.req_hartid_i[g], bus.req_id_i[g], bus.req_rd_i[g], 1'b1, 1'b0);
      step();
      set_req(g, ROR64H, $urandom, $urandom, 32'h0, bus.req_hartid_i[g],
              bus.req_id_i[g] + 8'd1, bus.req_rd_i[g] + 5'd1, 6'($urandom_range(0, 63)));
      g = (g == 2'd0) ? 2'd1 : 2'd0;
    end
    bus.req_valid_i = '0;
    repeat (3) step();

    // OP_ASCON from req1 with consumer stalled: two grants, then credit blocks
    bus.res_ready_i = 1'b0;
    set_req(1, OP_ASCON, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF, 4'h5, 8'h50, 5'd10, 6'd0);
    #1;
    chk("t3_grant0", bus.req_ready_o, 3'b010);
    push_exp(1, 32'hFF0F00F0, 4'h5, 8'h50, 5'd10, 1'b1, 1'b0);
    step();
    chk("t3_grant1", bus.req_ready_o, 3'b010);
    push_exp(1, 32'hFF0F00F0, 4'h5, 8'h50, 5'd10, 1'b1, 1'b0);
    step();
    chk("t3_block0", bus.req_ready_o, 3'b000);
    step();
    chk("t3_block1", bus.req_ready_o, 3'b000);
    chk("t3_head_valid", bus.res_valid_o, 1'b1);
    chk("t3_head_result", bus.res_result_o, 32'hFF0F00F0);
    step();
    chk("t3_hold_result", bus.res_result_o, 32'hFF0F00F0);
    bus.res_ready_i = 1'b1;
    #1;
    chk("t3_credit_back", bus.req_ready_o, 3'b010);
    push_exp(1, 32'hFF0F00F0, 4'h5, 8'h50, 5'd10, 1'b1, 1'b0);
    step();
    bus.req_valid_i = '0;
    repeat (4) step();

    // Unknown opcode from req0 reports an error, then a normal op follows
    set_req(0, opcode_t'(4'hE), 32'h1, 32'h2, 32'h3, 4'h3, 8'h44, 5'd7, 6'd0);
    #1;
    chk("t4_bad_grant", bus.req_ready_o, 3'b001);
    push_exp(0, 32'h0, 4'h3, 8'h44, 5'd7, 1'b0, 1'b1);
    step();
    set_req(0, ROR64H, 32'hAAAA5555, 32'h33CC33CC, 32'h0, 4'h2, 8'h45, 5'd9, 6'd16);
    #1;
    chk("t4_next_grant", bus.req_ready_o, 3'b001);
    push_exp(0, ror64h(32'hAAAA5555, 32'h33CC33CC, 6'd16), 4'h2, 8'h45, 5'd9, 1'b1, 1'b0);
    step();
    bus.req_valid_i = '0;
    #1;
    chk("t4_err", bus.res_err_o, 1'b1);
    chk("t4_err_we", bus.res_we_o, 1'b0);
    chk("t4_err_result", bus.res_result_o, 32'h0);
    step();
    chk("t4_ok_err", bus.res_err_o, 1'b0);
    chk("t4_ok_we", bus.res_we_o, 1'b1);
    repeat (2) step();

    // Entries queued and one in flight, then reset flushes everything
    bus.res_ready_i = 1'b0;
    set_req(0, ROR64H, 32'h11111111, 32'h22222222, 32'h0, 4'h1, 8'h60, 5'd3, 6'd4);
    #1;
    chk("t5_grant0", bus.req_ready_o, 3'b001);
    step();
    chk("t5_grant1", bus.req_ready_o, 3'b001);
    step();
    bus.req_valid_i = '0;
    #1;
    chk("t5_pre_rst_valid", bus.res_valid_o, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    bus.res_ready_i = 1'b1;
    set_req(0, ROR64H, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 4'h7, 8'h70, 5'd11, 6'd8);
    set_req(1, ROR64H, 32'h13579BDF, 32'h2468ACE0, 32'h0, 4'h8, 8'h71, 5'd12, 6'd20);
    #1;
    chk("t5_post_rst_valid", bus.res_valid_o, 1'b0);
    chk("t5_ptr_zero", bus.req_ready_o, 3'b001);
    push_exp(0, ror64h(32'h0000FFFF, 32'hFFFF0000, 6'd8), 4'h7, 8'h70, 5'd11, 1'b1, 1'b0);
    step();
    bus.req_valid_i[0] = 1'b0;
    #1;
    chk("t5_late_ignored", bus.res_valid_o, 1'b0);
    chk("t5_grant_req1", bus.req_ready_o, 3'b010);
    push_exp(1, ror64h(32'h13579BDF, 32'h2468ACE0, 6'd20), 4'h8, 8'h71, 5'd12, 1'b1, 1'b0);
    step();
    bus.req_valid_i = '0;

    // Pointer wrap: req2 alone, then req0 and req2 together
    step();
    set_req(2, OP_ASCON, 32'h12345678, 32'h0000FFFF, 32'hFFFFFFFF, 4'h9, 8'h80, 5'd13, 6'd0);
    #1;
    chk("t6_req2", bus.req_ready_o, 3'b100);
    push_exp(2, ascon(32'h12345678, 32'h0000FFFF, 32'hFFFFFFFF), 4'h9, 8'h80, 5'd13,
             1'b1, 1'b0);
    step();
    set_req(0, ROR64H, 32'hFEDCBA98, 32'h76543210, 32'h0, 4'hA, 8'h81, 5'd14, 6'd32);
    #1;
    chk("t6_wrap_req0", bus.req_ready_o, 3'b001);
    push_exp(0, 32'h76543210, 4'hA, 8'h81, 5'd14, 1'b1, 1'b0);
    step();
    bus.req_valid_i[0] = 1'b0;
    #1;
    chk("t6_req2_again", bus.req_ready_o, 3'b100);
    push_exp(2, ascon(32'h12345678, 32'h0000FFFF, 32'hFFFFFFFF), 4'h9, 8'h80, 5'd13,
             1'b1, 1'b0);
    step();
    bus.req_valid_i = '0;

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", bus.res_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
